// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole field controller.
// Hole states, LFSR seed/taps and the BCD digit limit.
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HIT  = 2'd2
    } hole_st_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  BCD_MAX   = 4'd9;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/wam_bcd2.sv
// Two-digit BCD score counter: wraps on increment, saturates at 00 on decrement.
// cout0 is a registered pulse on every units 9->0 wrap caused by an increment.
module wam_bcd2
    import wam_pkg::*;
(
    input  logic       clk_19,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] score,
    output logic       cout0
);

    logic [3:0] tens;
    logic [3:0] units;

    // Score digits and carry pulse; inc and dec together cancel out
    always_ff @(posedge clk_19 or posedge clr) begin
        if (clr) begin
            tens  <= 4'd0;
            units <= 4'd0;
            cout0 <= 1'b0;
        end else begin
            cout0 <= 1'b0;
            if (inc && !dec) begin
                if (units == BCD_MAX) begin
                    units <= 4'd0;
                    cout0 <= 1'b1;
                    tens  <= (tens == BCD_MAX) ? 4'd0 : tens + 4'd1;
                end else begin
                    units <= units + 4'd1;
                end
            end else if (dec && !inc) begin
                if (units != 4'd0) begin
                    units <= units - 4'd1;
                end else if (tens != 4'd0) begin
                    units <= BCD_MAX;
                    tens  <= tens - 4'd1;
                end
            end
        end
    end

    assign score = {tens, units};

endmodule

// File: rtl/wam_mol.sv
// Mole field controller: spawns moles pseudo-randomly, detects whacks, keeps score.
// Optional feature macro WAM_PENALTY_EN: whacking an empty hole costs one point.
module wam_mol
    import wam_pkg::*;
#(
    parameter int NHOLE    = 8,
    parameter int TICK_DIV = 65536
) (
    input  logic             clk_19,
    input  logic             clr,
    input  logic [NHOLE-1:0] hit,
    input  logic [3:0]       age,
    input  logic [7:0]       rto,
    output logic [NHOLE-1:0] mole,
    output logic [NHOLE-1:0] whk,
    output logic [7:0]       score,
    output logic             cout0
);

    localparam int HW = $clog2(NHOLE);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PTOP = PW'(TICK_DIV - 1);

    logic [PW-1:0]    presc;
    logic             step;
    logic [15:0]      lfsr;
    logic [NHOLE-1:0] hit_pre;
    logic [NHOLE-1:0] hedg;
    logic [NHOLE-1:0] up_v;
    logic [HW-1:0]    cand;
    logic             spawn;
    logic [3:0]       age1;
    logic             inc;
    logic             dec;
    hole_st_t         st   [NHOLE];
    logic [3:0]       life [NHOLE];

    assign step  = (presc == PTOP);
    assign hedg  = hit & ~hit_pre;
    assign cand  = lfsr[HW-1:0];
    assign spawn = step && (lfsr[15:8] < rto);
    assign age1  = (age == 4'd0) ? 4'd1 : age;

    // Game-step prescaler
    always_ff @(posedge clk_19 or posedge clr) begin
        if (clr) presc <= '0;
        else     presc <= step ? '0 : presc + PW'(1);
    end

    // Free-running LFSR and button history (all ones so held buttons never score)
    always_ff @(posedge clk_19 or posedge clr) begin
        if (clr) begin
            lfsr    <= LFSR_SEED;
            hit_pre <= '1;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr_fb(lfsr)};
            hit_pre <= hit;
        end
    end

    // Per-hole state machines with registered mole/whk outputs
    always_ff @(posedge clk_19 or posedge clr) begin
        if (clr) begin
            mole <= '0;
            whk  <= '0;
            for (int i = 0; i < NHOLE; i++) begin
                st[i]   <= IDLE;
                life[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NHOLE; i++) begin
                unique case (st[i])
                    IDLE: begin
                        if (spawn && cand == HW'(i)) begin
                            st[i]   <= UP;
                            life[i] <= age1;
                            mole[i] <= 1'b1;
                        end
                    end
                    UP: begin
                        if (hedg[i]) begin
                            st[i]   <= HIT;
                            mole[i] <= 1'b0;
                            whk[i]  <= 1'b1;
                        end else if (step) begin
                            if (life[i] == 4'd1) begin
                                st[i]   <= IDLE;
                                mole[i] <= 1'b0;
                            end else begin
                                life[i] <= life[i] - 4'd1;
                            end
                        end
                    end
                    HIT: begin
                        if (step) begin
                            st[i]  <= IDLE;
                            whk[i] <= 1'b0;
                        end
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

    // Which holes currently hold a raised mole
    always_comb begin
        up_v = '0;
        for (int i = 0; i < NHOLE; i++) up_v[i] = (st[i] == UP);
    end

    assign inc = |(hedg & up_v);

`ifdef WAM_PENALTY_EN
    logic [NHOLE-1:0] idle_v;

    // Which holes are empty, for the miss penalty
    always_comb begin
        idle_v = '0;
        for (int i = 0; i < NHOLE; i++) idle_v[i] = (st[i] == IDLE);
    end

    assign dec = |(hedg & idle_v);
`else
    assign dec = 1'b0;
`endif

    wam_bcd2 u_bcd (
        .clk_19 (clk_19),
        .clr    (clr),
        .inc    (inc),
        .dec    (dec),
        .score  (score),
        .cout0  (cout0)
    );

endmodule

// File: tb/tb_wam_mol.sv
// Self-checking bench for wam_mol: cycle model + scoreboard queue,
// table-driven phases and hand-written corner sequences.
module tb_wam_mol;

    localparam int NH = 8;
    localparam int TD = 4;

    logic          clk_19 = 1'b0;
    logic          clr;
    logic [NH-1:0] hit;
    logic [3:0]    age;
    logic [7:0]    rto;
    logic [NH-1:0] mole;
    logic [NH-1:0] whk;
    logic [7:0]    score;
    logic          cout0;

    always #5 clk_19 = ~clk_19;

    wam_mol #(.NHOLE(NH), .TICK_DIV(TD)) dut (
        .clk_19 (clk_19),
        .clr    (clr),
        .hit    (hit),
        .age    (age),
        .rto    (rto),
        .mole   (mole),
        .whk    (whk),
        .score  (score),
        .cout0  (cout0)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_pre;
    logic [15:0] m_lfsr;
    int          m_st   [NH];
    int          m_life [NH];
    int          m_score;
    bit          m_cout;
    logic [7:0]  m_hpre;

    typedef struct packed {
        logic [7:0] mole;
        logic [7:0] whk;
        logic [7:0] score;
        logic       cout0;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [3:0] age;
        logic [7:0] rto;
        int         ncyc;
        bit         track;
        bit         exp_empty;
    } vec_t;
    vec_t vecs[4];

    int  runlen [NH];
    bit  track_life = 1'b0;
    int  nruns = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exv);
        end
    endtask

    task automatic model_reset();
        m_pre   = 0;
        m_lfsr  = 16'hACE1;
        m_score = 0;
        m_cout  = 1'b0;
        m_hpre  = '1;
        for (int i = 0; i < NH; i++) begin
            m_st[i]   = 0;
            m_life[i] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] h);
        bit         stp;
        bit         sp;
        int         c;
        logic [7:0] he;
        int         ups;
        int         pen;
        bit         pn_ev;
        stp = (m_pre == TD - 1);
        c   = int'(m_lfsr) % NH;
        sp  = stp && (int'(m_lfsr >> 8) < int'(rto));
        he  = h & ~m_hpre;
        ups = 0;
        pen = 0;
        for (int i = 0; i < NH; i++) begin
            if (m_st[i] == 0) begin
                if (he[i]) pen++;
                if (sp && c == i) begin
                    m_st[i]   = 1;
                    m_life[i] = (age == 0) ? 1 : int'(age);
                end
            end else if (m_st[i] == 1) begin
                if (he[i]) begin
                    ups++;
                    m_st[i] = 2;
                end else if (stp) begin
                    if (m_life[i] == 1) m_st[i] = 0;
                    else m_life[i]--;
                end
            end else begin
                if (stp) m_st[i] = 0;
            end
        end
`ifdef WAM_PENALTY_EN
        pn_ev = (pen > 0);
`else
        pn_ev = 1'b0;
`endif
        m_cout = 1'b0;
        if (ups > 0 && !pn_ev) begin
            m_score = (m_score + 1) % 100;
            m_cout  = (m_score % 10 == 0);
        end else if (pn_ev && ups == 0 && m_score > 0) begin
            m_score--;
        end
        m_pre  = (m_pre + 1) % TD;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_hpre = h;
    endtask

    // one clock: drive, predict, push; then sample and pop
    task automatic cyc(input logic [7:0] h);
        exp_t e;
        exp_t a;
        @(negedge clk_19);
        hit = h;
        model_step(h);
        for (int i = 0; i < NH; i++) begin
            e.mole[i] = (m_st[i] == 1);
            e.whk[i]  = (m_st[i] == 2);
        end
        e.score = to_bcd(m_score);
        e.cout0 = m_cout;
        sbq.push_back(e);
        @(posedge clk_19);
        #1;
        a = {mole, whk, score, cout0};
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: got no entry expected one");
        end else begin
            e = sbq.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL sb @%0t: mole=%h/%h whk=%h/%h score=%h/%h cout0=%b/%b (got/expected)",
                         $time, a.mole, e.mole, a.whk, e.whk, a.score, e.score, a.cout0, e.cout0);
            end
        end
        for (int i = 0; i < NH; i++) begin
            if (mole[i]) begin
                runlen[i]++;
            end else if (runlen[i] > 0) begin
                if (track_life && !whk[i]) begin
                    chk("life_len", runlen[i], 12);
                    nruns++;
                end
                runlen[i] = 0;
            end
        end
    endtask

    task automatic find_up(output int h, output bit ok);
        ok = 1'b0;
        h  = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            for (int i = NH - 1; i >= 0; i--) if (m_st[i] == 1) begin h = i; ok = 1'b1; end
            if (!ok) cyc(8'h00);
        end
        if (!ok) chk("find_up_timeout", 0, 1);
    endtask

    task automatic find_idle(output int h, output bit ok);
        ok = 1'b0;
        h  = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (m_pre != TD - 1)
                for (int i = NH - 1; i >= 0; i--) if (m_st[i] == 0) begin h = i; ok = 1'b1; end
            if (!ok) cyc(8'h00);
        end
        if (!ok) chk("find_idle_timeout", 0, 1);
    endtask

    task automatic hit_up();
        int h;
        bit ok;
        find_up(h, ok);
        if (ok) begin
            cyc(8'(1 << h));
            cyc(8'h00);
        end
    endtask

    task automatic ramp_to(input int target);
        for (int g = 0; g < 150 && m_score != target; g++) hit_up();
        chk("ramp_score", {24'h0, score}, {24'h0, to_bcd(target)});
    endtask

    initial begin
        int   h;
        bit   ok;
        int   s;
        int   n;

        vecs[0] = '{age: 4'd3, rto: 8'd255, ncyc: 160, track: 1'b1, exp_empty: 1'b0};
        vecs[1] = '{age: 4'd0, rto: 8'd255, ncyc: 40,  track: 1'b0, exp_empty: 1'b0};
        vecs[2] = '{age: 4'd7, rto: 8'd100, ncyc: 60,  track: 1'b0, exp_empty: 1'b0};
        vecs[3] = '{age: 4'd2, rto: 8'd0,   ncyc: 40,  track: 1'b0, exp_empty: 1'b1};

        for (int i = 0; i < NH; i++) runlen[i] = 0;
        clr = 1'b1;
        hit = '1;
        age = 4'd3;
        rto = 8'd255;
        model_reset();
        repeat (3) @(negedge clk_19);
        chk("rst_mole",  {24'h0, mole},  0);
        chk("rst_whk",   {24'h0, whk},   0);
        chk("rst_score", {24'h0, score}, 0);
        chk("rst_cout0", {31'h0, cout0}, 0);
        chk("rst_lfsr",  {16'h0, dut.lfsr}, 32'hACE1);

        @(posedge clk_19);
        #2;
        clr = 1'b0;
        repeat (4) cyc(8'hFF);
        chk("held_hit_noscore", {24'h0, score}, 0);

        // table-driven phases with no whacks
        foreach (vecs[v]) begin
            age = vecs[v].age;
            rto = vecs[v].rto;
            track_life = vecs[v].track;
            s = m_score;
            for (int c = 0; c < vecs[v].ncyc; c++) cyc(8'h00);
            track_life = 1'b0;
            chk("vec_score", {24'h0, score}, {24'h0, to_bcd(s)});
            if (vecs[v].exp_empty)
                chk("vec_empty", {16'h0, mole, whk}, 0);
        end
        chk("life_runs_seen", (nruns > 0), 1);

        // mole in hole 2 whacked
        age = 4'd8;
        rto = 8'd255;
        ok  = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (m_st[2] == 1) ok = 1'b1;
            else cyc(8'h00);
        end
        chk("hole2_found", ok, 1);
        if (ok) begin
            s = m_score;
            cyc(8'h04);
            chk("hole2_whk",   whk[2],  1);
            chk("hole2_mole",  mole[2], 0);
            chk("hole2_score", {24'h0, score}, {24'h0, to_bcd((s + 1) % 100)});
            n = TD - m_pre;
            for (int c = 0; c < n; c++) cyc(8'h00);
            chk("hole2_hit_clear", whk[2], 0);
        end

        // units wrap 09 -> 10, then 99 -> 00
        ramp_to(9);
        find_up(h, ok);
        if (ok) begin
            cyc(8'(1 << h));
            chk("wrap10_score", {24'h0, score}, 32'h10);
            chk("wrap10_cout0", cout0, 1);
            cyc(8'h00);
            chk("wrap10_cout0_off", cout0, 0);
        end
        ramp_to(99);
        find_up(h, ok);
        if (ok) begin
            cyc(8'(1 << h));
            chk("wrap00_score", {24'h0, score}, 32'h00);
            chk("wrap00_cout0", cout0, 1);
            cyc(8'h00);
            chk("wrap00_cout0_off", cout0, 0);
        end

        // whack on empty hole at 00 and at 10
        find_idle(h, ok);
        if (ok) begin
            cyc(8'(1 << h));
            chk("miss_at_00", {24'h0, score}, 0);
            cyc(8'h00);
        end
        ramp_to(10);
        find_idle(h, ok);
        if (ok) begin
            cyc(8'(1 << h));
`ifdef WAM_PENALTY_EN
            chk("miss_at_10", {24'h0, score}, 32'h09);
`else
            chk("miss_at_10", {24'h0, score}, 32'h10);
`endif
            chk("miss_cout0", cout0, 0);
            cyc(8'h00);
        end

        // whack on the same edge as the last-life expiry step
        age = 4'd1;
        ok  = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (m_pre == TD - 1)
                for (int i = 0; i < NH; i++)
                    if (m_st[i] == 1 && m_life[i] == 1) begin h = i; ok = 1'b1; end
            if (!ok) cyc(8'h00);
        end
        chk("expiry_found", ok, 1);
        if (ok) begin
            s = m_score;
            cyc(8'(1 << h));
            chk("expiry_whk", whk[h], 1);
            chk("expiry_score", {24'h0, score}, {24'h0, to_bcd((s + 1) % 100)});
            cyc(8'h00);
        end

        // asynchronous clear mid-operation
        age = 4'd5;
        rto = 8'd255;
        repeat (20) cyc(8'h00);
        @(posedge clk_19);
        #3;
        clr = 1'b1;
        #1;
        chk("aclr_mole",  {24'h0, mole},  0);
        chk("aclr_whk",   {24'h0, whk},   0);
        chk("aclr_score", {24'h0, score}, 0);
        chk("aclr_lfsr",  {16'h0, dut.lfsr}, 32'hACE1);
        repeat (2) @(posedge clk_19);
        #2;
        clr = 1'b0;
        model_reset();
        repeat (30) cyc(8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wam_mol.md
# wam_mol

Mole field controller for the whack-a-mole game, directly downstream of the hardness stage. Consumes the current mole lifetime (`age`) and spawn ratio (`rto`), pseudo-randomly raises moles across a field of holes, and detects whacks from the player's hole buttons. Keeps a two-digit BCD score. Emits `cout0`, a one-cycle pulse on every units-digit wrap, which the hardness stage uses to step difficulty up.

## Interface
- `NHOLE`, 8: number of holes; power of two, 2..16.
- `TICK_DIV`, 2^16: `clk_19` cycles per game step; ≥2.
- `clk_19` in 1: system clock.
- `clr` in 1: reset; asynchronous, active-high.
- `hit` in NHOLE: whack buttons, one per hole, level, active high, already debounced.
- `age` in 4: mole lifetime in game steps; 0 treated as 1.
- `rto` in 8: spawn ratio; a spawn occurs when an 8-bit random draw < `rto`.
- `mole` out NHOLE: hole i shows a raised mole (state UP).
- `whk` out NHOLE: hole i shows a whacked mole (state HIT).
- `score` out 8: BCD score, tens in [7:4], units in [3:0], range 00–99.
- `cout0` out 1: one-cycle pulse when units wrap 9→0.

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps. The `step` strobe is high for one cycle at the terminal count.
- 16-bit Fibonacci LFSR, taps 16,14,13,11. It advances every cycle and never holds zero.
- Spawn draw uses `lfsr[15:8]`. Candidate hole is `lfsr[log2(NHOLE)-1:0]`.
- Hit edge detect: `hit_pre` is a register of `hit`. `hedg = hit & ~hit_pre`.
- Per-hole FSM with life counter `life[3:0]`:
  - IDLE → UP on `step` when this hole is the candidate and draw < `rto`. Loads `life` = max(`age`,1). At most one spawn per step.
  - UP, on `step`:
    - `life`==1 → IDLE (expired, no score).
    - otherwise `life` decrements.
  - UP with `hedg[i]` → HIT. `hedg` takes priority over a same-cycle expiry.
  - HIT → IDLE on the next `step`.
  - `hedg` on an IDLE or HIT hole has no effect on that hole.
- A candidate hole that is not IDLE gives no spawn for that step. There is no retry.
- Scoring:
  - If any UP hole sees `hedg` in a cycle, `score` increments by exactly 1. Simultaneous hits in several holes all move to HIT but earn one point.
  - BCD increment: units 9 → 0 with tens +1. 99 → 00.
  - `cout0` pulses on every units 9→0 transition, including 99→00.
- Outputs are registered: `mole[i]` = (state==UP), `whk[i]` = (state==HIT).

## Timing
- Reset values:
  - Outputs: `mole`=0, `whk`=0, `score`=8'h00, `cout0`=0.
  - Internal: prescaler=0, LFSR=16'hACE1, all holes IDLE, `hit_pre`=all ones, so buttons held through reset do not score.
- Hit latency: when `hit[i]` rises at edge n (UP hole), `whk[i]`=1, `mole[i]`=0 and the new `score` are visible after edge n+1. `cout0` is high for the same single cycle that the wrapped `score` first appears.
- Spawn and expiry take effect on the edge that samples `step`. The mole is visible in the following cycle.
- `age`/`rto` are sampled only at spawn. Changing them mid-life does not alter a running `life`.
- `clr` mid-operation clears everything immediately (async). Deassertion is synchronised in the reset tree outside this block.

## Configuration
- `WAM_PENALTY_EN`:
  - Defined: `hedg` on an IDLE hole decrements `score` by 1 in BCD (units 0 → 9 with tens −1). The decrement saturates at 00 and never pulses `cout0`. If a scoring hit and a penalty occur in the same cycle, the score is unchanged.
  - Undefined: whacks on empty holes are ignored.

## Structure
- Package `wam_pkg`:
  - hole state enum (IDLE/UP/HIT)
  - LFSR seed 16'hACE1 and tap mask
  - BCD max digit constant 4'd9
- Sub-module `wam_bcd2`: two-digit BCD counter with `inc`/`dec` inputs, saturating decrement, wrap-on-increment and registered `cout0`.

## Test plan
- Reset with `hit`=all ones held → no score after release; `score`=00, `mole`=0, LFSR=ACE1.
- TICK_DIV=4, `rto`=255, `age`=3, no hits → each spawned mole stays UP for exactly 3 steps (12 cycles), then returns to IDLE; `score` stays 00.
- Mole UP in hole 2, pulse `hit[2]` → one cycle later `whk[2]`=1, `mole[2]`=0, score 00→01; HIT clears at the next `step`.
- Preload score 09 by nine hits, then a tenth hit → `score`=10 and `cout0` high for exactly one cycle. At 99 a further hit gives 00 with a `cout0` pulse.
- `hit[i]` rises on the same cycle the UP hole's `life`==1 is stepped → HIT and score +1, no expiry.
- With `WAM_PENALTY_EN`, at score 00 whack an IDLE hole → score stays 00. At score 10 → 09, with no `cout0`.
